rc5_key_expand: RTL

RC5_KEY_EXPAND -- requirements
Module: rc5_key_expand

---
 rtl/rc5_key_expand.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rc5_key_expand.sv
// RC5-16 key expansion engine (w=16, b=16, c=8).
// Builds the S table (up to 64 words) from a 128-bit key in three phases:
// INIT fills S with the P/Q sequence one word per cycle, MIX performs one
// mixing iteration per cycle, and DONE pulses completion. The S table stays
// readable through a registered read port for the downstream cipher core.
module rc5_key_expand #(
    parameter logic [15:0] P_CONST = 16'hB7E1,
    parameter logic [15:0] Q_CONST = 16'h9E37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   num_rounds,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    input  logic [5:0]   s_rd_addr,
    output logic [15:0]  s_rd_data
);

    localparam int unsigned W      = 16;
    localparam int unsigned S_MAX  = 64;
    localparam int unsigned C_WRDS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [W-1:0]    s_mem [S_MAX];
    logic [W-1:0]    l_mem [C_WRDS];
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [5:0]      i_idx;
    logic [2:0]      j_idx;
    logic [7:0]      mix_cnt;
    logic [5:0]      t_last;
    logic [7:0]      n_last;

    logic [6:0]      t_w;
    logic [6:0]      t_eff;
    logic [7:0]      n_w;
    logic [W-1:0]    init_word;
    logic [W-1:0]    a_new;
    logic [W-1:0]    ab_sum;
    logic [W-1:0]    b_new;
    logic            accept;

    // Rotate left by the low four bits; an amount of zero returns x unchanged.
    function automatic logic [W-1:0] rotl16(input logic [W-1:0] x, input logic [3:0] s);
        logic [2*W-1:0] d;
        d = {x, x} << s;
        return d[2*W-1:W];
    endfunction

    // Table size, mix length, INIT word and one MIX iteration.
    always_comb begin
        t_w       = {1'b0, num_rounds, 1'b0} + 7'd2;
        t_eff     = (t_w < 7'd8) ? 7'd8 : t_w;
        n_w       = 8'(t_eff) * 8'd3;
        init_word = (i_idx == 6'd0) ? P_CONST : s_mem[i_idx - 6'd1] + Q_CONST;
        a_new     = rotl16(s_mem[i_idx] + a_reg + b_reg, 4'd3);
        ab_sum    = a_new + b_reg;
        b_new     = rotl16(l_mem[j_idx] + ab_sum, ab_sum[3:0]);
        accept    = (state == IDLE) && start;
    end

    // Control FSM, index/accumulator registers and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            mix_cnt   <= '0;
            t_last    <= '0;
            n_last    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        t_last    <= 6'(t_w - 7'd1);
                        n_last    <= n_w - 8'd1;
                        a_reg     <= '0;
                        b_reg     <= '0;
                        i_idx     <= '0;
                        j_idx     <= '0;
                        mix_cnt   <= '0;
                        busy      <= 1'b1;
                        key_valid <= 1'b0;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    if (i_idx == t_last) begin
                        i_idx <= '0;
                        state <= MIX;
                    end else begin
                        i_idx <= i_idx + 6'd1;
                    end
                end
                MIX: begin
                    a_reg   <= a_new;
                    b_reg   <= b_new;
                    i_idx   <= (i_idx == t_last) ? 6'd0 : i_idx + 6'd1;
                    j_idx   <= j_idx + 3'd1;
                    mix_cnt <= mix_cnt + 8'd1;
                    if (mix_cnt == n_last) begin
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // S and L storage; contents are don't-care until an expansion completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                for (int k = 0; k < int'(C_WRDS); k++) begin
                    l_mem[k] <= key[16*k +: 16];
                end
            end else if (state == INIT) begin
                s_mem[i_idx] <= init_word;
            end else if (state == MIX) begin
                s_mem[i_idx] <= a_new;
                l_mem[j_idx] <= b_new;
            end
        end
    end

    // Registered S-table read port, one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_rd_data <= '0;
        end else begin
            s_rd_data <= s_mem[s_rd_addr];
        end
    end

endmodule
